// File: rtl/fft_pkg.sv
// Shared constants, sample payload and state encoding for the FFT front end.
package fft_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned N_POINTS = 16;
    localparam int unsigned LOG2_N   = 4;

    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } sample_t;

    typedef enum logic {FILL, WAIT} state_e;

    function automatic logic [LOG2_N-1:0] bitrev4(input logic [LOG2_N-1:0] idx);
        return {idx[0], idx[1], idx[2], idx[3]};
    endfunction

endpackage

// File: rtl/fft_input_framer.sv
// Collects 16 complex samples into a fill buffer and publishes each complete
// frame on registered parallel buses, spacing publishes by at least HOLD_CYCLES.
module fft_input_framer
    import fft_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 24,
    parameter int unsigned BIT_REVERSE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sof,
    input  logic [SAMPLE_W-1:0] in_real,
    input  logic [SAMPLE_W-1:0] in_imag,
    output logic [SAMPLE_W-1:0] output_real0,
    output logic [SAMPLE_W-1:0] output_real1,
    output logic [SAMPLE_W-1:0] output_real2,
    output logic [SAMPLE_W-1:0] output_real3,
    output logic [SAMPLE_W-1:0] output_real4,
    output logic [SAMPLE_W-1:0] output_real5,
    output logic [SAMPLE_W-1:0] output_real6,
    output logic [SAMPLE_W-1:0] output_real7,
    output logic [SAMPLE_W-1:0] output_real8,
    output logic [SAMPLE_W-1:0] output_real9,
    output logic [SAMPLE_W-1:0] output_real10,
    output logic [SAMPLE_W-1:0] output_real11,
    output logic [SAMPLE_W-1:0] output_real12,
    output logic [SAMPLE_W-1:0] output_real13,
    output logic [SAMPLE_W-1:0] output_real14,
    output logic [SAMPLE_W-1:0] output_real15,
    output logic [SAMPLE_W-1:0] output_imag0,
    output logic [SAMPLE_W-1:0] output_imag1,
    output logic [SAMPLE_W-1:0] output_imag2,
    output logic [SAMPLE_W-1:0] output_imag3,
    output logic [SAMPLE_W-1:0] output_imag4,
    output logic [SAMPLE_W-1:0] output_imag5,
    output logic [SAMPLE_W-1:0] output_imag6,
    output logic [SAMPLE_W-1:0] output_imag7,
    output logic [SAMPLE_W-1:0] output_imag8,
    output logic [SAMPLE_W-1:0] output_imag9,
    output logic [SAMPLE_W-1:0] output_imag10,
    output logic [SAMPLE_W-1:0] output_imag11,
    output logic [SAMPLE_W-1:0] output_imag12,
    output logic [SAMPLE_W-1:0] output_imag13,
    output logic [SAMPLE_W-1:0] output_imag14,
    output logic [SAMPLE_W-1:0] output_imag15,
    output logic                new_input_flag,
    output logic [7:0]          frame_count,
    output logic [7:0]          drop_count
);

    localparam int unsigned       CNT_W     = 8;
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LOG2_N-1:0] LAST_IDX  = LOG2_N'(N_POINTS - 1);

    state_e            state_q, state_d;
    logic [LOG2_N-1:0] wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              flag_q, flag_d;
    sample_t           fill_q [N_POINTS];
    sample_t           fill_d [N_POINTS];
    sample_t           out_q  [N_POINTS];
    sample_t           out_d  [N_POINTS];

    logic              accept;
    logic              publish;
    logic [LOG2_N-1:0] wr_addr;
    sample_t           in_sample;

    assign in_ready = rst & (state_q == FILL);

    // Next-state: fill, resync on sof, publish when the hold interval allows.
    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        hold_cnt_d  = (hold_cnt_q == '0) ? '0 : hold_cnt_q - CNT_W'(1);
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        flag_d      = flag_q;
        fill_d      = fill_q;
        out_d       = out_q;
        publish     = 1'b0;
        accept      = in_valid && (state_q == FILL);
        in_sample   = '{re: in_real, im: in_imag};
        wr_addr     = in_sof ? '0 : ((BIT_REVERSE != 0) ? bitrev4(wr_idx_q) : wr_idx_q);

        case (state_q)
            FILL: begin
                if (accept) begin
                    fill_d[wr_addr] = in_sample;
                    if (in_sof) begin
                        wr_idx_d = LOG2_N'(1);
                        if (wr_idx_q != '0 && drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        end
                    end else if (wr_idx_q == LAST_IDX) begin
                        if (hold_cnt_q == '0) begin
                            publish = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        wr_idx_d = wr_idx_q + LOG2_N'(1);
                    end
                end
            end
            WAIT: begin
                if (hold_cnt_q == '0) begin
                    publish = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        // fill_d already carries the 16th sample when publishing on its accept edge.
        if (publish) begin
            out_d       = fill_d;
            hold_cnt_d  = HOLD_LOAD;
            flag_d      = ~flag_q;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            wr_idx_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            wr_idx_q    <= '0;
            hold_cnt_q  <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            flag_q      <= 1'b0;
            fill_q      <= '{default: '0};
            out_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            hold_cnt_q  <= hold_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            flag_q      <= flag_d;
            fill_q      <= fill_d;
            out_q       <= out_d;
        end
    end

    assign new_input_flag = flag_q;
    assign frame_count    = frame_cnt_q;
    assign drop_count     = drop_cnt_q;

    assign output_real0  = out_q[0].re;
    assign output_real1  = out_q[1].re;
    assign output_real2  = out_q[2].re;
    assign output_real3  = out_q[3].re;
    assign output_real4  = out_q[4].re;
    assign output_real5  = out_q[5].re;
    assign output_real6  = out_q[6].re;
    assign output_real7  = out_q[7].re;
    assign output_real8  = out_q[8].re;
    assign output_real9  = out_q[9].re;
    assign output_real10 = out_q[10].re;
    assign output_real11 = out_q[11].re;
    assign output_real12 = out_q[12].re;
    assign output_real13 = out_q[13].re;
    assign output_real14 = out_q[14].re;
    assign output_real15 = out_q[15].re;
    assign output_imag0  = out_q[0].im;
    assign output_imag1  = out_q[1].im;
    assign output_imag2  = out_q[2].im;
    assign output_imag3  = out_q[3].im;
    assign output_imag4  = out_q[4].im;
    assign output_imag5  = out_q[5].im;
    assign output_imag6  = out_q[6].im;
    assign output_imag7  = out_q[7].im;
    assign output_imag8  = out_q[8].im;
    assign output_imag9  = out_q[9].im;
    assign output_imag10 = out_q[10].im;
    assign output_imag11 = out_q[11].im;
    assign output_imag12 = out_q[12].im;
    assign output_imag13 = out_q[13].im;
    assign output_imag14 = out_q[14].im;
    assign output_imag15 = out_q[15].im;

endmodule

// File: tb/tb_fft_input_framer.sv
// Bench for fft_input_framer: two instances (HOLD 16 natural order, HOLD 24
// bit-reversed) on a shared stimulus, each checked against a frame-level model.
module tb_fft_input_framer;

    localparam int unsigned HOLD_A = 16;
    localparam int unsigned HOLD_B = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_sof;
    logic [15:0]       in_real;
    logic [15:0]       in_imag;
    logic [1:0]        rdy;
    logic [1:0]        flg;
    logic [1:0][7:0]   fcnt;
    logic [1:0][7:0]   dcnt;
    logic [15:0][15:0] re_a, im_a, re_b, im_b;

    always #5 clk = ~clk;

    fft_input_framer #(.HOLD_CYCLES(HOLD_A), .BIT_REVERSE(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_sof(in_sof),
        .in_real(in_real), .in_imag(in_imag),
        .output_real0(re_a[0]),   .output_real1(re_a[1]),   .output_real2(re_a[2]),   .output_real3(re_a[3]),
        .output_real4(re_a[4]),   .output_real5(re_a[5]),   .output_real6(re_a[6]),   .output_real7(re_a[7]),
        .output_real8(re_a[8]),   .output_real9(re_a[9]),   .output_real10(re_a[10]), .output_real11(re_a[11]),
        .output_real12(re_a[12]), .output_real13(re_a[13]), .output_real14(re_a[14]), .output_real15(re_a[15]),
        .output_imag0(im_a[0]),   .output_imag1(im_a[1]),   .output_imag2(im_a[2]),   .output_imag3(im_a[3]),
        .output_imag4(im_a[4]),   .output_imag5(im_a[5]),   .output_imag6(im_a[6]),   .output_imag7(im_a[7]),
        .output_imag8(im_a[8]),   .output_imag9(im_a[9]),   .output_imag10(im_a[10]), .output_imag11(im_a[11]),
        .output_imag12(im_a[12]), .output_imag13(im_a[13]), .output_imag14(im_a[14]), .output_imag15(im_a[15]),
        .new_input_flag(flg[0]), .frame_count(fcnt[0]), .drop_count(dcnt[0])
    );

    fft_input_framer #(.HOLD_CYCLES(HOLD_B), .BIT_REVERSE(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_sof(in_sof),
        .in_real(in_real), .in_imag(in_imag),
        .output_real0(re_b[0]),   .output_real1(re_b[1]),   .output_real2(re_b[2]),   .output_real3(re_b[3]),
        .output_real4(re_b[4]),   .output_real5(re_b[5]),   .output_real6(re_b[6]),   .output_real7(re_b[7]),
        .output_real8(re_b[8]),   .output_real9(re_b[9]),   .output_real10(re_b[10]), .output_real11(re_b[11]),
        .output_real12(re_b[12]), .output_real13(re_b[13]), .output_real14(re_b[14]), .output_real15(re_b[15]),
        .output_imag0(im_b[0]),   .output_imag1(im_b[1]),   .output_imag2(im_b[2]),   .output_imag3(im_b[3]),
        .output_imag4(im_b[4]),   .output_imag5(im_b[5]),   .output_imag6(im_b[6]),   .output_imag7(im_b[7]),
        .output_imag8(im_b[8]),   .output_imag9(im_b[9]),   .output_imag10(im_b[10]), .output_imag11(im_b[11]),
        .output_imag12(im_b[12]), .output_imag13(im_b[13]), .output_imag14(im_b[14]), .output_imag15(im_b[15]),
        .new_input_flag(flg[1]), .frame_count(fcnt[1]), .drop_count(dcnt[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level model: samples in arrival order, publish allowed once
    // HOLD edges have elapsed since the previous publish.
    logic [15:0][15:0] f_re [2];
    logic [15:0][15:0] f_im [2];
    logic [15:0][15:0] m_re [2];
    logic [15:0][15:0] m_im [2];
    int   m_idx [2];
    int   m_last [2];
    int   m_pubs [2];
    int   m_drop [2];
    int   m_fc [2];
    bit   m_pubbed [2];
    logic m_flag [2];
    int   edge_no;

    logic prev_flag [2];
    int   toggles [2];
    int   low_cnt [2];
    int   prev_pub_edge [2];
    int   gap [2];

    function automatic int hold_of(input int u);
        return (u == 0) ? int'(HOLD_A) : int'(HOLD_B);
    endfunction

    function automatic int map_idx(input int u, input int n);
        if (u == 0) return n;
        return ((n % 2) * 8) + (((n / 2) % 2) * 4) + (((n / 4) % 2) * 2) + ((n / 8) % 2);
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            f_re[u] = '0; f_im[u] = '0; m_re[u] = '0; m_im[u] = '0;
            m_idx[u] = 0; m_last[u] = 0; m_pubs[u] = 0; m_drop[u] = 0; m_fc[u] = 0;
            m_pubbed[u] = 1'b0; m_flag[u] = 1'b0;
            prev_flag[u] = 1'b0; toggles[u] = 0; low_cnt[u] = 0;
            prev_pub_edge[u] = 0; gap[u] = 0;
        end
        edge_no = 0;
    endtask

    task automatic model_step(input int u, input logic v, input logic s,
                              input logic [15:0] re, input logic [15:0] im);
        bit ready, allowed;
        ready   = m_idx[u] < 16;
        allowed = !m_pubbed[u] || (edge_no - m_last[u] >= hold_of(u));
        if (ready && v) begin
            if (s) begin
                if (m_idx[u] != 0 && m_drop[u] < 255) m_drop[u]++;
                f_re[u][0] = re; f_im[u][0] = im;
                m_idx[u] = 1;
            end else begin
                f_re[u][m_idx[u]] = re; f_im[u][m_idx[u]] = im;
                m_idx[u]++;
            end
        end
        if (m_idx[u] == 16 && allowed) begin
            for (int n = 0; n < 16; n++) begin
                m_re[u][map_idx(u, n)] = f_re[u][n];
                m_im[u][map_idx(u, n)] = f_im[u][n];
            end
            m_flag[u]   = ~m_flag[u];
            m_fc[u]     = (m_fc[u] + 1) % 256;
            m_idx[u]    = 0;
            m_last[u]   = edge_no;
            m_pubbed[u] = 1'b1;
            m_pubs[u]++;
        end
    endtask

    task automatic compare_all(input bit in_rst);
        logic [511:0] got;
        for (int u = 0; u < 2; u++) begin
            got = (u == 0) ? {re_a, im_a} : {re_b, im_b};
            check($sformatf("frame%0d", u), got, {m_re[u], m_im[u]});
            check($sformatf("ready%0d", u), 512'(rdy[u]), 512'(!in_rst && m_idx[u] < 16));
            check($sformatf("flag%0d", u), 512'(flg[u]), 512'(m_flag[u]));
            check($sformatf("fcnt%0d", u), 512'(fcnt[u]), 512'(m_fc[u]));
            check($sformatf("dcnt%0d", u), 512'(dcnt[u]), 512'(m_drop[u]));
            if (!in_rst && !rdy[u]) low_cnt[u]++;
            if (flg[u] !== prev_flag[u]) begin
                toggles[u]++;
                gap[u]           = edge_no - prev_pub_edge[u];
                prev_pub_edge[u] = edge_no;
                prev_flag[u]     = flg[u];
            end
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [15:0] re, input logic [15:0] im);
        @(negedge clk);
        compare_all(1'b0);
        in_valid = v; in_sof = s; in_real = re; in_imag = im;
        edge_no++;
        model_step(0, v, s, re, im);
        model_step(1, v, s, re, im);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all(1'b1);
        in_valid = 1'b0; in_sof = 1'b0;
        @(posedge clk);
        #1;
        compare_all(1'b1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_real = '0; in_imag = '0;
        do_reset();

        // Short frame at HOLD 16 streams without stalling.
        for (int n = 0; n < 16; n++)
            step(1'b1, 1'b0, (n < 4) ? 16'(n + 1) : 16'd0, (n < 4) ? 16'(n + 5) : 16'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_re%0d", k), 512'(re_a[k]), 512'(k + 1));
            check($sformatf("t1_im%0d", k), 512'(im_a[k]), 512'(k + 5));
        end
        check("t1_flag", 512'(flg[0]), 512'(1));
        check("t1_fcnt", 512'(fcnt[0]), 512'(1));
        check("t1_nostall", 512'(low_cnt[0]), 512'(0));

        // Second frame: HOLD 24 instance stalls 8 cycles after its 16th sample.
        for (int n = 0; n < 16; n++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
        for (int n = 0; n < 12; n++) step(1'b0, 1'b0, 16'd0, 16'd0);
        @(posedge clk); #1;
        check("t2_gap_b", 512'(gap[1]), 512'(24));
        check("t2_gap_a", 512'(gap[0]), 512'(16));
        check("t2_flag_b", 512'(flg[1]), 512'(0));
        check("t2_low_b", 512'(low_cnt[1]), 512'(8));

        // Bit-reversed placement.
        do_reset();
        for (int n = 0; n < 16; n++) step(1'b1, 1'b0, 16'(n), 16'd0);
        @(posedge clk); #1;
        check("t3_br1", 512'(re_b[1]), 512'(8));
        check("t3_br2", 512'(re_b[2]), 512'(4));
        check("t3_br3", 512'(re_b[3]), 512'(12));
        check("t3_br15", 512'(re_b[15]), 512'(15));
        check("t3_nat1", 512'(re_a[1]), 512'(1));

        // Resync mid-frame.
        do_reset();
        for (int n = 0; n < 5; n++) step(1'b1, 1'b0, 16'(10 + n), 16'(n));
        step(1'b1, 1'b1, 16'd100, 16'd7);
        for (int n = 0; n < 15; n++) step(1'b1, 1'b0, 16'(200 + n), 16'(n));
        @(posedge clk); #1;
        check("t4_drop_a", 512'(dcnt[0]), 512'(1));
        check("t4_drop_b", 512'(dcnt[1]), 512'(1));
        check("t4_re0_a", 512'(re_a[0]), 512'(100));
        check("t4_re0_b", 512'(re_b[0]), 512'(100));

        // Asynchronous reset mid-frame, then a clean frame.
        for (int n = 0; n < 9; n++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
        do_reset();
        for (int n = 0; n < 16; n++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
        @(posedge clk); #1;
        check("t5_fcnt_a", 512'(fcnt[0]), 512'(1));
        check("t5_fcnt_b", 512'(fcnt[1]), 512'(1));
        check("t5_drop_a", 512'(dcnt[0]), 512'(0));

        // Random valid, 300 frames through the HOLD 16 instance.
        do_reset();
        for (int c = 0; c < 20000 && m_pubs[0] < 300; c++)
            step(1'($urandom_range(0, 1)), 1'b0, 16'($urandom), 16'($urandom));
        step(1'b0, 1'b0, 16'd0, 16'd0);
        @(posedge clk); #1;
        check("t6_budget", 512'(m_pubs[0]), 512'(300));
        check("t6_fcnt", 512'(fcnt[0]), 512'(44));
        check("t6_toggles", 512'(toggles[0]), 512'(300));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
